flag_unit: RTL and testbench
============================

Name: flag_unit

Overview:
- Producer side of the NZCV flag interface. Derives N, Z, C, V from the ALU outputs and holds them in the architectural flag register that drives the Flags[3:0] input of the condition checker.
- Captures the checker's CondEx result into a per-instruction register.
- Gates the multicycle controller's write strobes (register, memory, flags, PC) with that captured result.
- Sits between the ALU / main FSM and the condition checker in the multicycle datapath.

Parameters:
- WIDTH, 32, ALU datapath width; N is taken from bit WIDTH-1, Z covers all WIDTH bits.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- ALUResult  input  WIDTH  ALU result, current cycle
- ALUCarryOut  input  1  adder carry-out (subtract is A + ~B + 1)
- SrcAMsb  input  1  bit WIDTH-1 of ALU operand A
- SrcBMsb  input  1  bit WIDTH-1 of ALU operand B, before inversion
- ALUControl  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- FlagW  input  2  bit1 requests an N,Z update; bit0 requests a C,V update
- CondEx  input  1  combinational result from the condition checker
- CondExCapture  input  1  FSM strobe, high for one cycle in Decode
- RegW  input  1  FSM register-write request
- MemW  input  1  FSM memory-write request
- PCS  input  1  instruction writes PC (branch or Rd=PC)
- NextPC  input  1  FSM unconditional PC update (fetch)
- Flags  output  4  {N,Z,C,V} architectural flags, registered
- CondExR  output  1  captured condition result, registered
- RegWrite  output  1  gated register-file write enable
- MemWrite  output  1  gated memory write enable
- PCWrite  output  1  gated PC write enable

Behaviour:
- Reset: on a rising clk edge with reset=1, Flags<=4'b0000 and CondExR<=0; this overrides all other inputs that cycle. The gated outputs then follow from CondExR=0.
- Flag derivation (combinational):
  - nN = ALUResult[WIDTH-1]
  - nZ = (ALUResult == 0)
  - nC = ALUCarryOut & ~ALUControl[1]
  - nV = ~(ALUControl[0]^SrcAMsb^SrcBMsb) & (SrcAMsb^ALUResult[WIDTH-1]) & ~ALUControl[1]
  - For logical ops (AND/ORR), nC=0 and nV=0.
- Capture:
  - On an edge with CondExCapture=1, CondExR<=CondEx.
  - Otherwise CondExR holds its value.
- Flag write:
  - FlagWrite[1:0] = FlagW & {2{CondExR}}.
  - On an edge with FlagWrite[1]=1, {N,Z}<={nN,nZ}.
  - On an edge with FlagWrite[0]=1, {C,V}<={nC,nV}.
  - Halves not enabled hold their values; no partial update within a half.
- Gated strobes (combinational from registered CondExR, no added latency):
  - RegWrite = RegW & CondExR
  - MemWrite = MemW & CondExR
  - PCWrite = NextPC | (PCS & CondExR)
- Simultaneous CondExCapture and FlagW/RegW/MemW/PCS in the same cycle: gating uses the old CondExR. The new value takes effect the following cycle.
- Flags changing in the same cycle CondExCapture is high does not affect the captured value. CondEx is sampled from the pre-edge Flags.
- Flags are visible on the output one cycle after the write edge.
- Reset mid-instruction: CondExR=0 immediately suppresses RegWrite, MemWrite and the PCS term. NextPC still passes.
- No X on outputs after the first reset edge. ALUControl values are exhaustive, so no default/X case is needed.

Optional Feature:
- Macro: CONDEX_BYPASS_EN.
- Defined: in a cycle with CondExCapture=1, gating uses the live CondEx input instead of CondExR, for FlagWrite, RegWrite, MemWrite and PCWrite. This supports FSMs that issue Decode and execute strobes in the same cycle. CondExR is still registered as normal.
- Undefined: gating always uses CondExR, as described in Behaviour.

Test Plan:
- Reset: assert reset for 2 cycles with FlagW=11, CondEx=1, CondExCapture=1 -> Flags=0000, CondExR=0, RegWrite=MemWrite=0 with RegW=MemW=1.
- SUB overflow: capture CondEx=1; then SrcA=0x80000000, SrcB=0x00000001, ALUResult=0x7FFFFFFF, ALUCarryOut=1, ALUControl=01, FlagW=11 -> next cycle Flags=0011.
- Zero/logical: AND with ALUResult=0, ALUCarryOut=1, FlagW=11, CondExR=1 -> Flags=0100 (C forced 0). Then FlagW=10 with ALUResult=0x80000000 -> Flags=1000, C/V retained.
- Condition failed: capture CondEx=0; then FlagW=11, RegW=1, MemW=1, PCS=1, NextPC=0 -> Flags unchanged, RegWrite=MemWrite=PCWrite=0. Then NextPC=1 -> PCWrite=1.
- Same-cycle capture: CondExR=1; CondExCapture=1 with CondEx=0 and RegW=1 -> RegWrite=1 this cycle (without CONDEX_BYPASS_EN), 0 the next cycle. With CONDEX_BYPASS_EN -> RegWrite=0 in both cycles.
- Half-write: FlagW=01, ADD with ALUResult=0, ALUCarryOut=1 -> only C,V update (C=1, V=0); N,Z hold their previous values.

Source files
------------

// File: rtl/flag_unit_if.sv
// rtl/flag_unit_if.sv - ALU/FSM-side and checker-side signal bundle for flag_unit.
interface flag_unit_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] ALUResult;
   logic             ALUCarryOut;
   logic             SrcAMsb;
   logic             SrcBMsb;
   logic [1:0]       ALUControl;
   logic [1:0]       FlagW;
   logic             CondEx;
   logic             CondExCapture;
   logic             RegW;
   logic             MemW;
   logic             PCS;
   logic             NextPC;
   logic [3:0]       Flags;
   logic             CondExR;
   logic             RegWrite;
   logic             MemWrite;
   logic             PCWrite;

   modport master (
      output ALUResult, ALUCarryOut, SrcAMsb, SrcBMsb, ALUControl, FlagW,
             CondEx, CondExCapture, RegW, MemW, PCS, NextPC,
      input  Flags, CondExR, RegWrite, MemWrite, PCWrite
   );

   modport slave (
      input  ALUResult, ALUCarryOut, SrcAMsb, SrcBMsb, ALUControl, FlagW,
             CondEx, CondExCapture, RegW, MemW, PCS, NextPC,
      output Flags, CondExR, RegWrite, MemWrite, PCWrite
   );
endinterface

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - NZCV flag register, CondEx capture and write-strobe gating.
// Optional CONDEX_BYPASS_EN: gate with live CondEx in the capture cycle.
module flag_unit #(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        reset,
   flag_unit_if.slave bus
);
   logic [3:0] flags_q;
   logic       condex_r;
   logic       n_n, n_z, n_c, n_v;
   logic       is_logic;
   logic       gate_en;
   logic [1:0] flag_write;

   always_comb begin
      is_logic = bus.ALUControl[1];
      n_n      = bus.ALUResult[WIDTH-1];
      n_z      = (bus.ALUResult == '0);
      n_c      = bus.ALUCarryOut & ~is_logic;
      // Overflow: operand signs agree (after SUB inversion of B) but result sign differs from A.
      n_v      = ~(bus.ALUControl[0] ^ bus.SrcAMsb ^ bus.SrcBMsb)
                 & (bus.SrcAMsb ^ bus.ALUResult[WIDTH-1]) & ~is_logic;
   end

   always_comb begin
`ifdef CONDEX_BYPASS_EN
      gate_en = bus.CondExCapture ? bus.CondEx : condex_r;
`else
      gate_en = condex_r;
`endif
      flag_write = bus.FlagW & {2{gate_en}};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q  <= 4'b0000;
         condex_r <= 1'b0;
      end else begin
         if (bus.CondExCapture)
            condex_r <= bus.CondEx;
         if (flag_write[1])
            flags_q[3:2] <= {n_n, n_z};
         if (flag_write[0])
            flags_q[1:0] <= {n_c, n_v};
      end
   end

   assign bus.Flags    = flags_q;
   assign bus.CondExR  = condex_r;
   assign bus.RegWrite = bus.RegW & gate_en;
   assign bus.MemWrite = bus.MemW & gate_en;
   assign bus.PCWrite  = bus.NextPC | (bus.PCS & gate_en);
endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - directed self-checking bench for flag_unit.
module tb_flag_unit;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   flag_unit_if #(.WIDTH(32)) bus ();

   flag_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      bus.ALUResult     = 32'h1234_5678;
      bus.ALUCarryOut   = 1'b0;
      bus.SrcAMsb       = 1'b0;
      bus.SrcBMsb       = 1'b0;
      bus.ALUControl    = 2'b00;
      bus.FlagW         = 2'b00;
      bus.CondEx        = 1'b0;
      bus.CondExCapture = 1'b0;
      bus.RegW          = 1'b0;
      bus.MemW          = 1'b0;
      bus.PCS           = 1'b0;
      bus.NextPC        = 1'b0;
   endtask

   task automatic capture(input logic value);
      bus.CondEx        = value;
      bus.CondExCapture = 1'b1;
      tick();
      bus.CondExCapture = 1'b0;
      bus.CondEx        = 1'b0;
   endtask

   task automatic alu(input logic [31:0] res, input logic cout, input logic amsb,
                      input logic bmsb, input logic [1:0] ctrl, input logic [1:0] fw);
      bus.ALUResult   = res;
      bus.ALUCarryOut = cout;
      bus.SrcAMsb     = amsb;
      bus.SrcBMsb     = bmsb;
      bus.ALUControl  = ctrl;
      bus.FlagW       = fw;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      idle();
      reset = 1'b1;

      // Reset holds even with every write request asserted
      alu(32'h0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b11);
      bus.CondEx = 1'b1;
      bus.CondExCapture = 1'b1;
      bus.RegW = 1'b1;
      bus.MemW = 1'b1;
      bus.PCS  = 1'b1;
      tick();
      tick();
      chk("reset_flags", bus.Flags, 4'b0000);
      chk("reset_condexr", bus.CondExR, 1'b0);
      bus.CondExCapture = 1'b0;
      settle();
      chk("reset_regwrite", bus.RegWrite, 1'b0);
      chk("reset_memwrite", bus.MemWrite, 1'b0);
      chk("reset_pcwrite", bus.PCWrite, 1'b0);
      idle();
      reset = 1'b0;
      tick();

      capture(1'b1);
      chk("capture_one", bus.CondExR, 1'b1);

      // SUB 0x80000000 - 1: signed overflow with carry
      alu(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 2'b01, 2'b11);
      settle();
      chk("sub_flags_not_yet", bus.Flags, 4'b0000);
      tick();
      chk("sub_overflow", bus.Flags, 4'b0011);

      alu(32'h0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b11);
      tick();
      chk("and_zero", bus.Flags, 4'b0100);

      alu(32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
      tick();
      chk("nz_only_neg", bus.Flags, 4'b1000);

      // ADD of two positives giving a negative result
      alu(32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11);
      tick();
      chk("add_overflow", bus.Flags, 4'b1001);

      bus.FlagW = 2'b00;
      capture(1'b0);
      chk("capture_zero", bus.CondExR, 1'b0);
      alu(32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
      bus.RegW = 1'b1;
      bus.MemW = 1'b1;
      bus.PCS  = 1'b1;
      settle();
      chk("fail_regwrite", bus.RegWrite, 1'b0);
      chk("fail_memwrite", bus.MemWrite, 1'b0);
      chk("fail_pcwrite", bus.PCWrite, 1'b0);
      tick();
      chk("fail_flags_held", bus.Flags, 4'b1001);
      bus.NextPC = 1'b1;
      settle();
      chk("fail_nextpc", bus.PCWrite, 1'b1);
      idle();

      capture(1'b1);
      chk("pass_regwrite_idle", bus.RegWrite, 1'b0);
      // Capture of a failing condition in the same cycle as the execute strobes
      bus.CondExCapture = 1'b1;
      bus.CondEx = 1'b0;
      bus.RegW = 1'b1;
      bus.MemW = 1'b1;
      bus.PCS  = 1'b1;
      alu(32'h0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b11);
      settle();
`ifdef CONDEX_BYPASS_EN
      chk("same_regwrite", bus.RegWrite, 1'b0);
      chk("same_memwrite", bus.MemWrite, 1'b0);
      chk("same_pcwrite", bus.PCWrite, 1'b0);
`else
      chk("same_regwrite", bus.RegWrite, 1'b1);
      chk("same_memwrite", bus.MemWrite, 1'b1);
      chk("same_pcwrite", bus.PCWrite, 1'b1);
`endif
      tick();
      bus.CondExCapture = 1'b0;
      bus.FlagW = 2'b00;
      settle();
`ifdef CONDEX_BYPASS_EN
      chk("same_flags", bus.Flags, 4'b1001);
`else
      chk("same_flags", bus.Flags, 4'b0100);
`endif
      chk("same_condexr", bus.CondExR, 1'b0);
      chk("same_regwrite_next", bus.RegWrite, 1'b0);
      idle();

      capture(1'b1);
      alu(32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11);
      tick();
      chk("orr_neg", bus.Flags, 4'b1000);
      alu(32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
      tick();
      chk("cv_half_write", bus.Flags, 4'b1010);

      // Reset mid-instruction drops the captured condition but not NextPC
      idle();
      bus.RegW = 1'b1;
      bus.PCS  = 1'b1;
      bus.NextPC = 1'b1;
      settle();
      chk("pre_reset_regwrite", bus.RegWrite, 1'b1);
      reset = 1'b1;
      tick();
      chk("midreset_flags", bus.Flags, 4'b0000);
      chk("midreset_regwrite", bus.RegWrite, 1'b0);
      chk("midreset_pcwrite", bus.PCWrite, 1'b1);
      bus.NextPC = 1'b0;
      settle();
      chk("midreset_pcs_gated", bus.PCWrite, 1'b0);
      reset = 1'b0;
      idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
